branch_resolve_unit: RTL and testbench
======================================

Name: branch_resolve_unit

Overview:
- EXE-stage consumer of the IF branch predictor's per-instruction prediction (PResult).
- Compares the prediction against the actual branch outcome and produces the registered BResult correction record that the predictor uses to update its BHT and RAS.
- Issues a handshaked front-end redirect on misprediction.
- Handles MIPS delay-slot ordering: a redirect is never issued before the delay slot has reached ID.

Parameters:
- RESET_PC, 32'hBFC00000, value driven on Redirect_PC while no redirect is pending.

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous reset, active-high
- EXE_Valid  input  1  valid instruction in EXE
- EXE_Wr  input  1  EXE register advancing this cycle
- EXE_Flush  input  1  exception/external flush of EXE and later stages
- EXE_PC  input  32  PC of EXE instruction
- EXE_BType  input  2  BIsNone/BIsImme/BIsCall/BIsRetn, from decode
- EXE_IsTaken  input  1  actual branch direction
- EXE_ActTarget  input  32  actual taken target
- EXE_PResult  input  PResult  prediction carried down the pipe (IsTaken, Target, Type, Count, Hit, Valid)
- ID_DSValid  input  1  delay-slot instruction present in ID
- Redirect_Ack  input  1  PCSel/IF accepted redirect this cycle
- EXE_BResult  output  BResult  correction record (Valid, PC, Target, Type, IsTaken, Hit, Count)
- Redirect_Valid  output  1  redirect request pending
- Redirect_PC  output  32  redirect address
- Flush_IF  output  1  flush PREIF/IF (never ID), equals Redirect_Valid & Redirect_Ack
- BRU_Busy  output  1  hold EXE; high in WAIT_DS and REDIR
- Branch_Cnt  output  32  resolved-branch counter
- Mispred_Cnt  output  32  misprediction counter

Behaviour:
- Reset values:
  - All outputs 0 except Redirect_PC = RESET_PC.
  - FSM = IDLE; Resolved flag = 0.
- Resolve condition, evaluated in cycle N: EXE_Valid & EXE_BType != BIsNone & !Resolved & !EXE_Flush & state == IDLE.
- Predicted direction:
  - PT = EXE_PResult.Valid & EXE_PResult.IsTaken.
  - If EXE_PResult.Valid = 0, the prediction is not-taken (fall-through was fetched).
- Misprediction:
  - Mispredict = (PT != EXE_IsTaken) | (PT & EXE_IsTaken & EXE_PResult.Target != EXE_ActTarget).
  - Correct PC = EXE_IsTaken ? EXE_ActTarget : EXE_PC + 8; 32-bit wrap-around.
- BResult timing: registered. In cycle N+1, EXE_BResult.Valid = 1 for exactly one cycle, with:
  - PC = EXE_PC, Target = EXE_ActTarget, Type = EXE_BType, IsTaken = EXE_IsTaken.
  - Hit and Count copied from EXE_PResult.
  - BResult is emitted on every resolved branch, correct or not.
- Resolved flag:
  - Set on resolve when EXE_Wr = 0; cleared when EXE_Wr = 1 or EXE_Flush = 1.
  - A stalled branch therefore produces exactly one BResult.
- FSM states: IDLE, WAIT_DS, REDIR.
  - IDLE → REDIR on resolve & Mispredict & ID_DSValid.
  - IDLE → WAIT_DS on resolve & Mispredict & !ID_DSValid.
  - WAIT_DS → REDIR when ID_DSValid = 1.
  - REDIR → IDLE when Redirect_Ack = 1.
- Redirect_PC is latched at resolve and held until acknowledged.
- Redirect_Valid = (state == REDIR). It is first asserted at N+1 at the earliest and held stable until Redirect_Ack.
- Ack arriving in the same cycle REDIR is entered is honoured; the pending redirect is one cycle long.
- Resolve attempts while state != IDLE are ignored (EXE is held by BRU_Busy); the bench asserts this never occurs.
- EXE_Flush in any state:
  - State → IDLE, Resolved cleared, pending redirect dropped.
  - Any BResult due in the following cycle is suppressed.
  - Priority: rst > EXE_Flush > resolve.
- Asynchronous rst mid-redirect: all outputs drop immediately, no partial BResult.

Optional Feature:
- Macro: BRU_PERF_CNT_EN.
- Defined:
  - Branch_Cnt increments on every emitted BResult.
  - Mispred_Cnt increments on every emitted BResult with Mispredict.
  - Both are 32-bit, saturate at 32'hFFFFFFFF, reset to 0, and are unaffected by EXE_Flush after emission.
- Undefined: both outputs tied to 0 and no counter flops are synthesised.

Test Plan:
- Correct prediction: BImme PC=0x1000, PResult{Valid=1,IsTaken=1,Target=0x2000}, actual taken→0x2000 → N+1 BResult.Valid=1, IsTaken=1; Redirect_Valid stays 0.
- Not-taken mispredict, DS present: PC=0x1000, PT=1, actual not-taken, ID_DSValid=1 → N+1 Redirect_Valid=1, Redirect_PC=0x1008; Ack at N+1 → Flush_IF=1, state IDLE at N+2.
- Delay slot late: mispredict actual taken→0x3000, ID_DSValid=0 for 3 cycles → BRU_Busy=1, Redirect_Valid=0 until DS arrives; then Redirect_PC=0x3000, held until Ack.
- Stalled branch: branch in EXE with EXE_Wr=0 for 4 cycles → exactly one BResult.Valid pulse; Branch_Cnt +1 with BRU_PERF_CNT_EN.
- Target mismatch with invalid prediction: PResult.Valid=0, actual taken→0x4000 → mispredict, Redirect_PC=0x4000; a second case with PT=1, Target=0x5000, actual 0x4000 → mispredict.
- Flush in WAIT_DS: mispredict with ID_DSValid=0, then EXE_Flush=1 → state IDLE, Redirect_Valid never asserted, BRU_Busy drops next cycle.

Source files
------------

// File: rtl/branch_resolve_unit.sv
// Branch resolve unit (EXE stage).
// Compares the IF predictor's per-instruction prediction against the actual
// branch outcome, emits a one-cycle registered BResult correction record for
// every resolved branch, and issues a handshaked front-end redirect on a
// misprediction once the delay slot has reached ID.
//
// Packed bus layouts (MSB first):
//   EXE_PResult [38:0] = {Valid, Hit, Count[1:0], Type[1:0], IsTaken, Target[31:0]}
//   EXE_BResult [70:0] = {Valid, PC[31:0], Target[31:0], Type[1:0], IsTaken, Hit, Count[1:0]}
// Branch types: 0 = BIsNone, 1 = BIsImme, 2 = BIsCall, 3 = BIsRetn.
//
// Optional feature: define BRU_PERF_CNT_EN to build the saturating
// resolved-branch and misprediction counters; otherwise both read as 0.
module branch_resolve_unit #(
    parameter logic [31:0] RESET_PC = 32'hBFC00000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        EXE_Valid,
    input  logic        EXE_Wr,
    input  logic        EXE_Flush,
    input  logic [31:0] EXE_PC,
    input  logic [1:0]  EXE_BType,
    input  logic        EXE_IsTaken,
    input  logic [31:0] EXE_ActTarget,
    input  logic [38:0] EXE_PResult,
    input  logic        ID_DSValid,
    input  logic        Redirect_Ack,
    output logic [70:0] EXE_BResult,
    output logic        Redirect_Valid,
    output logic [31:0] Redirect_PC,
    output logic        Flush_IF,
    output logic        BRU_Busy,
    output logic [31:0] Branch_Cnt,
    output logic [31:0] Mispred_Cnt
);

    localparam logic [1:0] BIS_NONE = 2'd0;

    typedef struct packed {
        logic        valid;
        logic        hit;
        logic [1:0]  count;
        logic [1:0]  btype;
        logic        is_taken;
        logic [31:0] target;
    } presult_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] target;
        logic [1:0]  btype;
        logic        is_taken;
        logic        hit;
        logic [1:0]  count;
    } bresult_t;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT_DS = 2'd1,
        S_REDIR   = 2'd2
    } state_t;

    state_t      state_q;
    state_t      state_d;
    presult_t    pres;
    bresult_t    bres_q;
    logic        resolved_q;
    logic [31:0] redir_pc_q;
    logic        pred_taken;
    logic        mispredict;
    logic        resolve;
    logic [31:0] correct_pc;
    logic        pres_type_unused;

    assign pres = EXE_PResult;

    // The branch type is already known from decode; the prediction's copy
    // of it plays no part in deciding whether the front end went wrong.
    assign pres_type_unused = ^pres.btype;

    // An invalid prediction means the fall-through path was fetched.
    assign pred_taken = pres.valid & pres.is_taken;
    assign mispredict = (pred_taken != EXE_IsTaken) |
                        (pred_taken & EXE_IsTaken & (pres.target != EXE_ActTarget));
    assign correct_pc = EXE_IsTaken ? EXE_ActTarget : EXE_PC + 32'd8;

    // A branch resolves once: only while idle, not yet resolved during this
    // EXE residency, and not being flushed away.
    assign resolve = EXE_Valid & (EXE_BType != BIS_NONE) & ~resolved_q &
                     ~EXE_Flush & (state_q == S_IDLE);

    // State register for the redirect sequencer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // flop samples pre-edge values regardless of block ordering.
            state_q <= state_d;
        end
    end

    // Next-state logic: flush wins, then the delay-slot wait and ack handshake.
    always_comb begin
        // NOTE: default first, so no path leaves state_d unassigned (no latch).
        state_d = state_q;
        if (EXE_Flush) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (resolve & mispredict) begin
                        state_d = ID_DSValid ? S_REDIR : S_WAIT_DS;
                    end
                end
                S_WAIT_DS: begin
                    if (ID_DSValid) begin
                        state_d = S_REDIR;
                    end
                end
                S_REDIR: begin
                    if (Redirect_Ack) begin
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Resolved flag keeps a stalled branch from producing a second BResult.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resolved_q <= 1'b0;
        end else if (EXE_Flush | EXE_Wr) begin
            resolved_q <= 1'b0;
        end else if (resolve) begin
            resolved_q <= 1'b1;
        end
    end

    // Redirect address: captured at a mispredicting resolve, held until acked.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            redir_pc_q <= RESET_PC;
        end else if (EXE_Flush) begin
            redir_pc_q <= RESET_PC;
        end else if (resolve & mispredict) begin
            redir_pc_q <= correct_pc;
        end else if ((state_q == S_REDIR) & Redirect_Ack) begin
            redir_pc_q <= RESET_PC;
        end
    end

    // Correction record: valid pulses for one cycle after each resolve.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bres_q <= '0;
        end else begin
            bres_q.valid <= resolve;
            if (resolve) begin
                bres_q.pc       <= EXE_PC;
                bres_q.target   <= EXE_ActTarget;
                bres_q.btype    <= EXE_BType;
                bres_q.is_taken <= EXE_IsTaken;
                bres_q.hit      <= pres.hit;
                bres_q.count    <= pres.count;
            end
        end
    end

    assign EXE_BResult    = bres_q;
    assign Redirect_Valid = (state_q == S_REDIR);
    assign Redirect_PC    = redir_pc_q;
    assign Flush_IF       = Redirect_Valid & Redirect_Ack;
    assign BRU_Busy       = (state_q != S_IDLE);

`ifdef BRU_PERF_CNT_EN
    logic [31:0] branch_cnt_q;
    logic [31:0] mispred_cnt_q;

    // Saturating counters, stepped together with the BResult they describe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else if (resolve) begin
            if (branch_cnt_q != 32'hFFFFFFFF) begin
                branch_cnt_q <= branch_cnt_q + 32'd1;
            end
            if (mispredict && (mispred_cnt_q != 32'hFFFFFFFF)) begin
                mispred_cnt_q <= mispred_cnt_q + 32'd1;
            end
        end
    end

    assign Branch_Cnt  = branch_cnt_q;
    assign Mispred_Cnt = mispred_cnt_q;
`else
    assign Branch_Cnt  = 32'd0;
    assign Mispred_Cnt = 32'd0;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Testbench for branch_resolve_unit: directed scenarios followed by random
// traffic, every cycle compared against a behavioural model of the
// prediction/redirect rules.
module tb_branch_resolve_unit;

    localparam logic [31:0] RESET_PC = 32'hBFC00000;

    typedef struct packed {
        logic        valid;
        logic        hit;
        logic [1:0]  count;
        logic [1:0]  btype;
        logic        is_taken;
        logic [31:0] target;
    } presult_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] target;
        logic [1:0]  btype;
        logic        is_taken;
        logic        hit;
        logic [1:0]  count;
    } bresult_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        EXE_Valid;
    logic        EXE_Wr;
    logic        EXE_Flush;
    logic [31:0] EXE_PC;
    logic [1:0]  EXE_BType;
    logic        EXE_IsTaken;
    logic [31:0] EXE_ActTarget;
    logic [38:0] EXE_PResult;
    logic        ID_DSValid;
    logic        Redirect_Ack;
    logic [70:0] EXE_BResult;
    logic        Redirect_Valid;
    logic [31:0] Redirect_PC;
    logic        Flush_IF;
    logic        BRU_Busy;
    logic [31:0] Branch_Cnt;
    logic [31:0] Mispred_Cnt;

    always #5 clk = ~clk;

    branch_resolve_unit #(.RESET_PC(RESET_PC)) dut (
        .clk           (clk),
        .rst           (rst),
        .EXE_Valid     (EXE_Valid),
        .EXE_Wr        (EXE_Wr),
        .EXE_Flush     (EXE_Flush),
        .EXE_PC        (EXE_PC),
        .EXE_BType     (EXE_BType),
        .EXE_IsTaken   (EXE_IsTaken),
        .EXE_ActTarget (EXE_ActTarget),
        .EXE_PResult   (EXE_PResult),
        .ID_DSValid    (ID_DSValid),
        .Redirect_Ack  (Redirect_Ack),
        .EXE_BResult   (EXE_BResult),
        .Redirect_Valid(Redirect_Valid),
        .Redirect_PC   (Redirect_PC),
        .Flush_IF      (Flush_IF),
        .BRU_Busy      (BRU_Busy),
        .Branch_Cnt    (Branch_Cnt),
        .Mispred_Cnt   (Mispred_Cnt)
    );

    int unsigned checks = 0;
    int unsigned errors = 0;

    // Reference model: "a redirect is owed" plus "the delay slot has been seen".
    bit          m_redirect;
    bit          m_ds_seen;
    bit          m_resolved;
    logic [31:0] m_target;
    bresult_t    m_bres;
    longint      m_branches;
    longint      m_mispreds;

    task automatic check(input string tag, input logic [70:0] obs, input logic [70:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] cnt_exp(input longint n);
        logic [31:0] sat;
        sat = (n > 64'h00000000FFFFFFFF) ? 32'hFFFFFFFF : n[31:0];
`ifdef BRU_PERF_CNT_EN
        return sat;
`else
        return sat & 32'd0;
`endif
    endfunction

    task automatic model_reset();
        m_redirect = 1'b0;
        m_ds_seen  = 1'b0;
        m_resolved = 1'b0;
        m_target   = RESET_PC;
        m_bres     = '0;
        m_branches = 0;
        m_mispreds = 0;
    endtask

    // Apply this cycle's inputs to the model; results describe the next cycle.
    task automatic model_step();
        presult_t    p;
        bit          can_resolve;
        bit          requesting;
        bit          pt;
        bit          wrong;
        p           = EXE_PResult;
        requesting  = m_redirect && m_ds_seen;
        can_resolve = EXE_Valid && (EXE_BType != 2'd0) && !m_resolved && !m_redirect && !EXE_Flush;
        m_bres      = '0;
        if (EXE_Flush) begin
            m_redirect = 1'b0;
            m_ds_seen  = 1'b0;
            m_resolved = 1'b0;
        end else begin
            if (m_redirect) begin
                if (requesting) begin
                    if (Redirect_Ack) m_redirect = 1'b0;
                end else if (ID_DSValid) begin
                    m_ds_seen = 1'b1;
                end
            end
            if (can_resolve) begin
                pt    = p.valid && p.is_taken;
                wrong = (pt != EXE_IsTaken) || (pt && EXE_IsTaken && p.target != EXE_ActTarget);
                m_bres.valid    = 1'b1;
                m_bres.pc       = EXE_PC;
                m_bres.target   = EXE_ActTarget;
                m_bres.btype    = EXE_BType;
                m_bres.is_taken = EXE_IsTaken;
                m_bres.hit      = p.hit;
                m_bres.count    = p.count;
                m_branches++;
                if (wrong) begin
                    m_mispreds++;
                    m_redirect = 1'b1;
                    m_ds_seen  = ID_DSValid;
                    m_target   = EXE_IsTaken ? EXE_ActTarget : EXE_PC + 32'd8;
                end
            end
            if (EXE_Wr) m_resolved = 1'b0;
            else if (can_resolve) m_resolved = 1'b1;
        end
    endtask

    task automatic compare_all();
        bresult_t obs;
        obs = EXE_BResult;
        check("bres_valid", obs.valid, m_bres.valid);
        if (m_bres.valid) check("bres_record", EXE_BResult, m_bres);
        check("redirect_valid", Redirect_Valid, m_redirect && m_ds_seen);
        check("redirect_pc", Redirect_PC, m_redirect ? m_target : RESET_PC);
        check("busy", BRU_Busy, m_redirect);
        check("branch_cnt", Branch_Cnt, cnt_exp(m_branches));
        check("mispred_cnt", Mispred_Cnt, cnt_exp(m_mispreds));
    endtask

    // Inputs are driven just after a rising edge; one call covers one cycle.
    task automatic cycle();
        #3;
        check("flush_if", Flush_IF, m_redirect && m_ds_seen && Redirect_Ack);
        model_step();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic set_branch(input logic [31:0] pc, input logic [1:0] btype, input bit taken,
                              input logic [31:0] act, input bit pv, input bit pt, input logic [31:0] ptgt);
        presult_t p;
        p.valid    = pv;
        p.hit      = 1'b1;
        p.count    = 2'd2;
        p.btype    = btype;
        p.is_taken = pt;
        p.target   = ptgt;
        EXE_Valid     = 1'b1;
        EXE_PC        = pc;
        EXE_BType     = btype;
        EXE_IsTaken   = taken;
        EXE_ActTarget = act;
        EXE_PResult   = p;
    endtask

    task automatic set_plain();
        EXE_Valid   = 1'b1;
        EXE_BType   = 2'd0;
        EXE_IsTaken = 1'b0;
        EXE_PResult = '0;
    endtask

    initial begin
        bresult_t    obs;
        presult_t    rp;
        int          pulses;
        logic [31:0] cnt_before;
        logic [31:0] cnt_want;
        bit          advance;

        rst = 1'b1;
        EXE_Valid = 1'b0; EXE_Wr = 1'b0; EXE_Flush = 1'b0; EXE_PC = '0;
        EXE_BType = '0; EXE_IsTaken = 1'b0; EXE_ActTarget = '0; EXE_PResult = '0;
        ID_DSValid = 1'b0; Redirect_Ack = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        compare_all();
        check("reset_flush_if", Flush_IF, 1'b0);

        // Correct taken prediction: record emitted, no redirect.
        set_branch(32'h1000, 2'd1, 1'b1, 32'h2000, 1'b1, 1'b1, 32'h2000);
        EXE_Wr = 1'b1; ID_DSValid = 1'b1;
        cycle();
        obs = EXE_BResult;
        check("t1_bres_valid", obs.valid, 1'b1);
        check("t1_bres_taken", obs.is_taken, 1'b1);
        check("t1_no_redirect", Redirect_Valid, 1'b0);
        set_plain();
        cycle();
        obs = EXE_BResult;
        check("t1_single_pulse", obs.valid, 1'b0);

        // Predicted taken, actually not taken, delay slot already in ID.
        set_branch(32'h1000, 2'd1, 1'b0, 32'h2000, 1'b1, 1'b1, 32'h2000);
        cycle();
        check("t2_redirect_valid", Redirect_Valid, 1'b1);
        check("t2_redirect_pc", Redirect_PC, 32'h1008);
        set_plain(); EXE_Wr = 1'b0; Redirect_Ack = 1'b1;
        #1;
        check("t2_flush_if", Flush_IF, 1'b1);
        cycle();
        check("t2_back_idle", BRU_Busy, 1'b0);
        Redirect_Ack = 1'b0; EXE_Wr = 1'b1;

        // Delay slot arrives late: busy without redirect until it shows up.
        set_branch(32'h1100, 2'd1, 1'b1, 32'h3000, 1'b1, 1'b0, 32'h0);
        ID_DSValid = 1'b0;
        cycle();
        set_plain(); EXE_Wr = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("t3_busy_wait", BRU_Busy, 1'b1);
            check("t3_no_redirect_yet", Redirect_Valid, 1'b0);
            cycle();
        end
        ID_DSValid = 1'b1;
        cycle();
        check("t3_redirect_valid", Redirect_Valid, 1'b1);
        check("t3_redirect_pc", Redirect_PC, 32'h3000);
        cycle();
        check("t3_redirect_held", Redirect_Valid, 1'b1);
        check("t3_pc_held", Redirect_PC, 32'h3000);
        Redirect_Ack = 1'b1;
        cycle();
        check("t3_acked", Redirect_Valid, 1'b0);
        Redirect_Ack = 1'b0; EXE_Wr = 1'b1;

        // Stalled branch: one record across four held cycles.
        cnt_before = Branch_Cnt;
        pulses = 0;
        set_branch(32'h2000, 2'd2, 1'b1, 32'h2400, 1'b1, 1'b1, 32'h2400);
        EXE_Wr = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cycle();
            obs = EXE_BResult;
            if (obs.valid) pulses++;
        end
        EXE_Wr = 1'b1;
        cycle();
        obs = EXE_BResult;
        if (obs.valid) pulses++;
        set_plain();
        cycle();
        obs = EXE_BResult;
        if (obs.valid) pulses++;
        check("t4_one_pulse", pulses, 1);
        cnt_want = cnt_before + 32'd1;
`ifndef BRU_PERF_CNT_EN
        cnt_want = 32'd0;
`endif
        check("t4_branch_cnt", Branch_Cnt, cnt_want);

        // Invalid prediction treated as not-taken.
        set_branch(32'h1200, 2'd1, 1'b1, 32'h4000, 1'b0, 1'b1, 32'h4000);
        cycle();
        check("t5a_redirect_valid", Redirect_Valid, 1'b1);
        check("t5a_redirect_pc", Redirect_PC, 32'h4000);
        set_plain(); EXE_Wr = 1'b0; Redirect_Ack = 1'b1;
        cycle();
        Redirect_Ack = 1'b0; EXE_Wr = 1'b1;

        // Right direction, wrong target.
        set_branch(32'h1300, 2'd3, 1'b1, 32'h4000, 1'b1, 1'b1, 32'h5000);
        cycle();
        check("t5b_redirect_valid", Redirect_Valid, 1'b1);
        check("t5b_redirect_pc", Redirect_PC, 32'h4000);
        set_plain(); EXE_Wr = 1'b0; Redirect_Ack = 1'b1;
        cycle();
        Redirect_Ack = 1'b0; EXE_Wr = 1'b1;

        // Fall-through address wraps past the top of the address space.
        set_branch(32'hFFFFFFFC, 2'd1, 1'b0, 32'h10, 1'b1, 1'b1, 32'h10);
        cycle();
        check("wrap_redirect_pc", Redirect_PC, 32'h00000004);
        set_plain(); EXE_Wr = 1'b0; Redirect_Ack = 1'b1;
        cycle();
        Redirect_Ack = 1'b0; EXE_Wr = 1'b1;

        // Flush while waiting for the delay slot drops the redirect.
        set_branch(32'h1400, 2'd1, 1'b1, 32'h6000, 1'b1, 1'b0, 32'h0);
        ID_DSValid = 1'b0;
        cycle();
        check("t6_busy", BRU_Busy, 1'b1);
        set_plain(); EXE_Wr = 1'b0; EXE_Flush = 1'b1;
        cycle();
        check("t6_busy_dropped", BRU_Busy, 1'b0);
        check("t6_no_redirect", Redirect_Valid, 1'b0);
        EXE_Flush = 1'b0; ID_DSValid = 1'b1; EXE_Wr = 1'b1;
        cycle();
        check("t6_never_redirects", Redirect_Valid, 1'b0);

        // Flush in the resolve cycle suppresses the record.
        set_branch(32'h1500, 2'd1, 1'b1, 32'h7000, 1'b1, 1'b1, 32'h7000);
        EXE_Flush = 1'b1;
        cycle();
        obs = EXE_BResult;
        check("t7_bres_suppressed", obs.valid, 1'b0);
        EXE_Flush = 1'b0;
        set_plain();
        cycle();

        // Asynchronous reset while a redirect is pending.
        set_branch(32'h1600, 2'd1, 1'b0, 32'h0, 1'b1, 1'b1, 32'h8000);
        cycle();
        check("t8_redirect_up", Redirect_Valid, 1'b1);
        set_plain(); EXE_Wr = 1'b0;
        #2;
        rst = 1'b1;
        Redirect_Ack = 1'b1;
        #1;
        check("t8_rv_dropped", Redirect_Valid, 1'b0);
        check("t8_busy_dropped", BRU_Busy, 1'b0);
        check("t8_flush_if_dropped", Flush_IF, 1'b0);
        check("t8_bres_cleared", EXE_BResult, 71'd0);
        check("t8_pc_reset", Redirect_PC, RESET_PC);
        check("t8_branch_cnt", Branch_Cnt, 32'd0);
        check("t8_mispred_cnt", Mispred_Cnt, 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0; Redirect_Ack = 1'b0; EXE_Wr = 1'b1;
        compare_all();

        // Random traffic; EXE is held whenever the unit reports busy.
        advance = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            if (advance) begin
                EXE_Valid     = ($urandom_range(0, 4) != 0);
                EXE_BType     = 2'($urandom_range(0, 3));
                EXE_PC        = ($urandom_range(0, 15) == 0) ? 32'hFFFFFFFC : ($urandom() & 32'hFFFFFFFC);
                EXE_IsTaken   = 1'($urandom_range(0, 1));
                EXE_ActTarget = $urandom() & 32'hFFFFFFFC;
                rp.valid      = ($urandom_range(0, 3) != 0);
                rp.hit        = 1'($urandom_range(0, 1));
                rp.count      = 2'($urandom_range(0, 3));
                rp.btype      = EXE_BType;
                rp.is_taken   = 1'($urandom_range(0, 1));
                rp.target     = ($urandom_range(0, 3) != 0) ? EXE_ActTarget : ($urandom() & 32'hFFFFFFFC);
                EXE_PResult   = rp;
            end
            EXE_Wr       = m_redirect ? 1'b0 : ($urandom_range(0, 3) != 0);
            EXE_Flush    = ($urandom_range(0, 24) == 0);
            ID_DSValid   = ($urandom_range(0, 2) != 0);
            Redirect_Ack = 1'($urandom_range(0, 1));
            advance      = EXE_Wr || EXE_Flush;
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
